// File: rtl/mdr_mem_if_if.sv
// Memory-side bus of the MDR: request/write-qualifier/address/data out, read data and ack back.
// The MDR controller uses the master modport; the memory model or macro uses the slave modport.
interface mdr_mem_if_if;
  logic        mem_req;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mdr_mem_if.sv
// Memory data register with a single-outstanding read/write handshake to memory.
// MDR_TIMEOUT_EN adds a wait-cycle timeout that aborts to IDLE with a sticky err flag.
module mdr_mem_if #(
  parameter logic [31:0] INIT_VAL       = 32'h00000000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [31:0]       BusMuxOut,
  input  logic              MDRin,
  input  logic              MDRout,
  input  logic              rd_start,
  input  logic              wr_start,
  input  logic [8:0]        mar_q,
  mdr_mem_if_if.master      mem,
  output logic [31:0]       mdr_q,
  output logic [31:0]       mdr_bus,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] mdr_d;
  logic [8:0]  addr_q, addr_d;

`ifdef MDR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             expired;

  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d = state_q;
    mdr_d   = mdr_q;
    addr_d  = addr_q;
`ifdef MDR_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        // A read start beats both a simultaneous write start and an MDR load.
        if (rd_start) begin
          addr_d  = mar_q;
          state_d = RD_WAIT;
`ifdef MDR_TIMEOUT_EN
          cnt_d   = '0;
          err_d   = 1'b0;
`endif
        end else begin
          if (MDRin) mdr_d = BusMuxOut;
          if (wr_start) begin
            addr_d  = mar_q;
            state_d = WR_WAIT;
`ifdef MDR_TIMEOUT_EN
            cnt_d   = '0;
            err_d   = 1'b0;
`endif
          end
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (mem.mem_ack) begin
          if (state_q == RD_WAIT) mdr_d = mem.mem_rdata;
          state_d = DONE;
        end
`ifdef MDR_TIMEOUT_EN
        else if (expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      mdr_q   <= INIT_VAL;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      mdr_q   <= mdr_d;
      addr_q  <= addr_d;
    end
  end

`ifdef MDR_TIMEOUT_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // All handshake outputs decode straight from the registered state.
  assign mem.mem_req   = (state_q == RD_WAIT) || (state_q == WR_WAIT);
  assign mem.mem_we    = (state_q == WR_WAIT);
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = mdr_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign mdr_bus       = MDRout ? mdr_q : 32'h0;

endmodule

// File: tb/tb_mdr_mem_if.sv
// Directed test of mdr_mem_if: MDR load/drive, read, write, arbitration, busy-ignore, reset, timeout.
module tb_mdr_mem_if;
  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] BusMuxOut;
  logic        MDRin, MDRout, rd_start, wr_start;
  logic [8:0]  mar_q;
  logic [31:0] mdr_q, mdr_bus;
  logic        busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  mdr_mem_if_if mem();

  mdr_mem_if dut (
    .clk       (clk),
    .clr       (clr),
    .BusMuxOut (BusMuxOut),
    .MDRin     (MDRin),
    .MDRout    (MDRout),
    .rd_start  (rd_start),
    .wr_start  (wr_start),
    .mar_q     (mar_q),
    .mem       (mem.master),
    .mdr_q     (mdr_q),
    .mdr_bus   (mdr_bus),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks += 6;
    if (mdr_q !== 32'h0)        begin n_fail++; $display("FAIL reset_mdr got=%h exp=00000000", mdr_q); end
    if (mem.mem_req !== 1'b0)   begin n_fail++; $display("FAIL reset_req got=%b exp=0", mem.mem_req); end
    if (mem.mem_we !== 1'b0)    begin n_fail++; $display("FAIL reset_we got=%b exp=0", mem.mem_we); end
    if (mem.mem_addr !== 9'h0)  begin n_fail++; $display("FAIL reset_addr got=%h exp=000", mem.mem_addr); end
    if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
    if (err !== 1'b0)           begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
    clr = 1'b0;
  endtask

  task automatic test_mdr_load();
    MDRin = 1'b1; BusMuxOut = 32'hDEADBEEF;
    tick();
    MDRin = 1'b0; BusMuxOut = 32'h0;
    MDRout = 1'b1; #1;
    n_checks += 3;
    if (mdr_q !== 32'hDEADBEEF)   begin n_fail++; $display("FAIL load_mdr got=%h exp=deadbeef", mdr_q); end
    if (mdr_bus !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bus_on got=%h exp=deadbeef", mdr_bus); end
    MDRout = 1'b0; #1;
    if (mdr_bus !== 32'h0)        begin n_fail++; $display("FAIL bus_off got=%h exp=00000000", mdr_bus); end
  endtask

  task automatic test_read();
    mar_q = 9'h05A; rd_start = 1'b1;
    tick();
    rd_start = 1'b0; mar_q = 9'h1FF;
    n_checks += 4;
    if (mem.mem_req !== 1'b1)    begin n_fail++; $display("FAIL rd_req got=%b exp=1", mem.mem_req); end
    if (mem.mem_we !== 1'b0)     begin n_fail++; $display("FAIL rd_we got=%b exp=0", mem.mem_we); end
    if (mem.mem_addr !== 9'h05A) begin n_fail++; $display("FAIL rd_addr got=%h exp=05a", mem.mem_addr); end
    if (busy !== 1'b1)           begin n_fail++; $display("FAIL rd_busy got=%b exp=1", busy); end
    tick(); tick();
    n_checks += 2;
    if (mem.mem_req !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL rd_wait got req=%b done=%b exp req=1 done=0", mem.mem_req, done); end
    if (mem.mem_addr !== 9'h05A) begin n_fail++; $display("FAIL rd_addr_hold got=%h exp=05a", mem.mem_addr); end
    mem.mem_ack = 1'b1; mem.mem_rdata = 32'h12345678;
    tick();
    mem.mem_ack = 1'b0; mem.mem_rdata = 32'h0;
    n_checks += 3;
    if (mdr_q !== 32'h12345678) begin n_fail++; $display("FAIL rd_data got=%h exp=12345678", mdr_q); end
    if (done !== 1'b1)          begin n_fail++; $display("FAIL rd_done got=%b exp=1", done); end
    if (mem.mem_req !== 1'b0)   begin n_fail++; $display("FAIL rd_req_drop got=%b exp=0", mem.mem_req); end
    tick();
    n_checks += 1;
    if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rd_done_len got done=%b busy=%b exp 0 0", done, busy); end
  endtask

  task automatic test_write();
    MDRin = 1'b1; BusMuxOut = 32'hA5A5A5A5;
    tick();
    MDRin = 1'b0; mar_q = 9'h0C3; wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    n_checks += 4;
    if (mem.mem_req !== 1'b1 || mem.mem_we !== 1'b1) begin n_fail++; $display("FAIL wr_req_we got=%b%b exp=11", mem.mem_req, mem.mem_we); end
    if (mem.mem_wdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL wr_wdata got=%h exp=a5a5a5a5", mem.mem_wdata); end
    if (mem.mem_addr !== 9'h0C3) begin n_fail++; $display("FAIL wr_addr got=%h exp=0c3", mem.mem_addr); end
    mem.mem_ack = 1'b1; mem.mem_rdata = 32'hFFFF0000;
    tick();
    mem.mem_ack = 1'b0;
    if (done !== 1'b1 || mem.mem_req !== 1'b0 || mem.mem_we !== 1'b0) begin n_fail++; $display("FAIL wr_done got done=%b req=%b we=%b exp 1 0 0", done, mem.mem_req, mem.mem_we); end
    n_checks += 1;
    if (mdr_q !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL wr_mdr_keep got=%h exp=a5a5a5a5", mdr_q); end
    tick();
  endtask

  task automatic test_ignore_busy();
    mar_q = 9'h011; rd_start = 1'b1;
    tick();
    rd_start = 1'b0; wr_start = 1'b1; MDRin = 1'b1; BusMuxOut = 32'h1; mar_q = 9'h022;
    tick();
    wr_start = 1'b0; MDRin = 1'b0;
    n_checks += 3;
    if (mem.mem_we !== 1'b0)     begin n_fail++; $display("FAIL busy_we got=%b exp=0", mem.mem_we); end
    if (mdr_q !== 32'hA5A5A5A5)  begin n_fail++; $display("FAIL busy_mdrin got=%h exp=a5a5a5a5", mdr_q); end
    if (mem.mem_addr !== 9'h011) begin n_fail++; $display("FAIL busy_addr got=%h exp=011", mem.mem_addr); end
    mem.mem_ack = 1'b1; mem.mem_rdata = 32'hCAFEF00D;
    tick();
    mem.mem_ack = 1'b0;
    n_checks += 1;
    if (mdr_q !== 32'hCAFEF00D || done !== 1'b1) begin n_fail++; $display("FAIL busy_rd_done got mdr=%h done=%b exp cafef00d 1", mdr_q, done); end
    tick();
  endtask

  task automatic test_arbitration();
    // rd+wr+MDRin together: read only, MDR not loaded from the bus
    rd_start = 1'b1; wr_start = 1'b1; MDRin = 1'b1; BusMuxOut = 32'h55555555; mar_q = 9'h100;
    tick();
    rd_start = 1'b0; wr_start = 1'b0; MDRin = 1'b0;
    n_checks += 2;
    if (mem.mem_req !== 1'b1 || mem.mem_we !== 1'b0) begin n_fail++; $display("FAIL both_rd got req=%b we=%b exp 1 0", mem.mem_req, mem.mem_we); end
    if (mdr_q !== 32'hCAFEF00D) begin n_fail++; $display("FAIL both_no_load got=%h exp=cafef00d", mdr_q); end
    mem.mem_ack = 1'b1; mem.mem_rdata = 32'h0000BEEF;
    tick();
    mem.mem_ack = 1'b0;
    n_checks += 1;
    if (mdr_q !== 32'h0000BEEF || done !== 1'b1) begin n_fail++; $display("FAIL min_latency got mdr=%h done=%b exp 0000beef 1", mdr_q, done); end
    tick();
    // MDRin with wr_start: load first, write carries the bus value
    wr_start = 1'b1; MDRin = 1'b1; BusMuxOut = 32'h0BADCAFE;
    tick();
    wr_start = 1'b0; MDRin = 1'b0;
    n_checks += 1;
    if (mem.mem_wdata !== 32'h0BADCAFE || mem.mem_we !== 1'b1) begin n_fail++; $display("FAIL wr_load got wdata=%h we=%b exp 0badcafe 1", mem.mem_wdata, mem.mem_we); end
    mem.mem_ack = 1'b1;
    tick();
    mem.mem_ack = 1'b0;
    tick();
    // ack while idle does nothing
    mem.mem_ack = 1'b1; mem.mem_rdata = 32'h77777777;
    tick();
    mem.mem_ack = 1'b0;
    n_checks += 1;
    if (mdr_q !== 32'h0BADCAFE || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL idle_ack got mdr=%h busy=%b done=%b exp 0badcafe 0 0", mdr_q, busy, done); end
  endtask

  task automatic test_clr_mid();
    mar_q = 9'h0AA; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    #2 clr = 1'b1;
    #1;
    n_checks += 2;
    if (mem.mem_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL clr_mid got req=%b busy=%b exp 0 0", mem.mem_req, busy); end
    if (mdr_q !== 32'h0 || mem.mem_addr !== 9'h0) begin n_fail++; $display("FAIL clr_mid_regs got mdr=%h addr=%h exp 0 0", mdr_q, mem.mem_addr); end
    #1 clr = 1'b0;
    mar_q = 9'h0BB; wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    n_checks += 1;
    if (busy !== 1'b1 || mem.mem_we !== 1'b1 || mem.mem_addr !== 9'h0BB) begin n_fail++; $display("FAIL clr_accept got busy=%b we=%b addr=%h exp 1 1 0bb", busy, mem.mem_we, mem.mem_addr); end
    mem.mem_ack = 1'b1;
    tick();
    mem.mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int  cycles;
    logic saw_done;
    cycles = 0; saw_done = 1'b0;
    mar_q = 9'h033; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done === 1'b1) saw_done = 1'b1;
      if (mem.mem_req !== 1'b1 && cycles == 0) cycles = i;
    end
`ifdef MDR_TIMEOUT_EN
    n_checks += 4;
    if (cycles != 16)       begin n_fail++; $display("FAIL to_cycles got=%0d exp=16", cycles); end
    if (err !== 1'b1)       begin n_fail++; $display("FAIL to_err got=%b exp=1", err); end
    if (saw_done !== 1'b0)  begin n_fail++; $display("FAIL to_done got=%b exp=0", saw_done); end
    if (mdr_q !== 32'h0)    begin n_fail++; $display("FAIL to_mdr got=%h exp=00000000", mdr_q); end
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    n_checks += 1;
    if (err !== 1'b0 || mem.mem_req !== 1'b1) begin n_fail++; $display("FAIL to_err_clear got err=%b req=%b exp 0 1", err, mem.mem_req); end
`else
    n_checks += 3;
    if (cycles != 0)        begin n_fail++; $display("FAIL wait_forever dropped at cycle %0d exp never", cycles); end
    if (err !== 1'b0)       begin n_fail++; $display("FAIL no_to_err got=%b exp=0", err); end
    if (saw_done !== 1'b0)  begin n_fail++; $display("FAIL no_to_done got=%b exp=0", saw_done); end
`endif
    mem.mem_ack = 1'b1; mem.mem_rdata = 32'h31415926;
    tick();
    mem.mem_ack = 1'b0;
    n_checks += 1;
    if (mdr_q !== 32'h31415926 || done !== 1'b1) begin n_fail++; $display("FAIL late_ack got mdr=%h done=%b exp 31415926 1", mdr_q, done); end
    tick();
  endtask

  initial begin
    clr = 1'b1; BusMuxOut = '0; MDRin = 1'b0; MDRout = 1'b0;
    rd_start = 1'b0; wr_start = 1'b0; mar_q = '0;
    mem.mem_ack = 1'b0; mem.mem_rdata = '0;
    #1;
    test_reset();
    tick();
    test_mdr_load();
    test_read();
    test_write();
    test_ignore_busy();
    test_arbitration();
    test_clr_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
